// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output buffer.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A fetch address is usable when it is word aligned and inside the memory.
  function automatic logic pc_legal(input logic [ADDR_W-1:0] pc,
                                    input logic [ADDR_W-1:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of (pc, instr) entries between the memory response and decode.
// Flush wins over push and pop; push into a full buffer is accepted only alongside a pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  fetch_entry_t     i_push_entry,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the PC, issues word reads to the instruction memory and hands
// (pc, instr) pairs to decode; redirects restart fetch, bad addresses park it in FAULT.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 8,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_instr,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [ADDR_W-1:0]  o_out_pc,
  output logic [INSTR_W-1:0] o_out_instr,
  output logic               o_fetch_fault,
  output logic [0:0]         o_dbg_state
);

  localparam int                CNT_W    = $clog2(BUF_DEPTH) + 1;
  localparam int                OCC_W    = CNT_W + 1;
  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(4 * MEM_WORDS);
  localparam logic [0:0]        ST_RUN   = FETCH_RUN;
  localparam logic [0:0]        ST_FAULT = FETCH_FAULT;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [0:0]        r_state;
  logic              r_epoch;
  logic              r_inflight;
  logic              r_tag_epoch;
  logic [ADDR_W-1:0] r_tag_pc;

  logic [0:0]        w_state_next;
  logic [CNT_W-1:0]  w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic [OCC_W-1:0]  w_occupancy;
  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic              w_pc_legal;
  logic              w_issue;
  logic              w_fault_entry;

  // Decode handshake: an entry transfers in every cycle where o_out_valid and
  // i_out_ready are both high; while valid is high and ready low the head is held.
  assign w_pop = o_out_valid & i_out_ready;

  // Entries held plus the one response still on its way, after this cycle's pop,
  // must leave a free slot before another read may be issued.
  assign w_occupancy = {1'b0, w_count}
                     + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_pop};
  assign w_room      = w_occupancy < OCC_W'(BUF_DEPTH);

  assign w_pc_legal    = pc_legal(r_fetch_pc, PC_LIMIT);
  assign w_issue       = (r_state == ST_RUN) && !i_redirect_valid && w_room && w_pc_legal;
  assign w_fault_entry = (r_state == ST_RUN) && !i_redirect_valid && w_room && !w_pc_legal;

  // Responses from before the latest redirect carry a stale epoch and are dropped.
  assign w_push       = r_inflight && (r_tag_epoch == r_epoch);
  assign w_push_entry = '{pc: r_tag_pc, instr: i_imem_instr};

  always_comb begin
    w_state_next = r_state;
    if (i_redirect_valid) begin
      if (pc_legal(i_redirect_pc, PC_LIMIT)) begin
        w_state_next = ST_RUN;
      end
    end else if (w_fault_entry) begin
      w_state_next = ST_FAULT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pc  <= RESET_PC;
      r_state     <= ST_RUN;
      r_epoch     <= 1'b0;
      r_inflight  <= 1'b0;
      r_tag_epoch <= 1'b0;
      r_tag_pc    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (i_redirect_valid) begin
        r_epoch    <= ~r_epoch;
        r_fetch_pc <= i_redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_issue) begin
        r_tag_pc    <= r_fetch_pc;
        r_tag_epoch <= r_epoch;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_redirect_valid),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign o_imem_addr   = r_fetch_pc;
  assign o_out_valid   = (w_count != '0);
  assign o_out_pc      = w_head.pc;
  assign o_out_instr   = w_head.instr;
  assign o_fetch_fault = (r_state == ST_FAULT);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized bench for instruction_fetch_unit against a stream-level model:
// each reset/redirect defines the expected pc sequence target, target+4, ... up to the memory end.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_WORDS = 8;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] LIMIT     = 32'(4 * MEM_WORDS);

  logic        clk;
  logic        i_reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        out_valid;
  logic        i_out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;
  logic [0:0]  dbg_state;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .o_imem_addr      (imem_addr),
    .i_imem_instr     (imem_instr),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_out_valid      (out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_pc         (out_pc),
    .o_out_instr      (out_instr),
    .o_fetch_fault    (fetch_fault),
    .o_dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'(MEM_WORDS));
  endfunction

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < LIMIT);
  endfunction

  // memory model: registered read of the word at the presented address
  always @(posedge clk) imem_instr <= mem[word_idx(imem_addr)];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic build_stream(input logic [31:0] t);
    exp_q.delete();
    if (t[1:0] == 2'b00) begin
      for (longint p = t; p < LIMIT; p += 4) exp_q.push_back(32'(p));
    end
  endtask

  // scoreboard for the current cycle, then advance one clock
  task automatic tick();
    logic [31:0] want;
    if (out_valid === 1'b1) begin
      check1("out_pc_legal", is_legal(out_pc), 1'b1);
      check32("out_instr", out_instr, mem[word_idx(out_pc)]);
      if (i_out_ready && !i_reset) begin
        check1("stream_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check32("stream_pc", out_pc, want);
        end
      end
    end
    if (i_reset) build_stream(RESET_PC);
    else if (i_redirect_valid) build_stream(i_redirect_pc);
    @(posedge clk);
    #1;
  endtask

  // driver: one-cycle redirect pulse, then the fixed R+1..R+3 behaviour; returns in R+3
  task automatic redirect_to(input logic [31:0] t, input logic rdy);
    logic ok;
    ok = is_legal(t);
    i_out_ready      = rdy;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = t;
    tick();
    i_redirect_valid = 1'b0;
    check1("rd_valid_r1", out_valid, 1'b0);
    check32("rd_addr_r1", imem_addr, t);
    if (ok) check1("rd_fault_r1", fetch_fault, 1'b0);
    tick();
    check1("rd_valid_r2", out_valid, 1'b0);
    if (!ok) check1("rd_fault_r2", fetch_fault, 1'b1);
    tick();
    if (ok) begin
      check1("rd_valid_r3", out_valid, 1'b1);
      check32("rd_pc_r3", out_pc, t);
    end else begin
      check1("rd_valid_r3_bad", out_valid, 1'b0);
      check1("rd_fault_r3_bad", fetch_fault, 1'b1);
    end
  endtask

  task automatic drain_and_check(input int cycles);
    i_out_ready = 1'b1;
    repeat (cycles) tick();
    check1("drain_empty", exp_q.size() == 0, 1'b1);
    check1("drain_valid", out_valid, 1'b0);
    check1("drain_fault", fetch_fault, 1'b1);
    check1("drain_state", dbg_state == FETCH_FAULT, 1'b1);
  endtask

  initial begin
    logic [31:0] t;
    int          r;
    n_tests          = 0;
    n_fail           = 0;
    i_reset          = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_out_ready      = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom() ^ (32'(i) << 28);
    repeat (2) @(posedge clk);
    #1;

    // reset values
    check32("rst_imem_addr", imem_addr, RESET_PC);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_out_instr", out_instr, 32'h0);
    check1("rst_fault", fetch_fault, 1'b0);
    check1("rst_state", dbg_state == FETCH_RUN, 1'b1);

    // full sequential run 0..28 with decode always ready
    i_reset     = 1'b0;
    i_out_ready = 1'b1;
    build_stream(RESET_PC);
    check32("c0_imem_addr", imem_addr, RESET_PC);
    for (int c = 0; c <= 11; c++) begin
      if (c < 2 || c >= 10) check1("seq_valid_low", out_valid, 1'b0);
      if (c >= 2 && c <= 9) begin
        check1("seq_valid", out_valid, 1'b1);
        check32("seq_pc", out_pc, RESET_PC + 32'(4 * (c - 2)));
      end
      if (c == 8) check1("seq_fault_c8", fetch_fault, 1'b0);
      if (c == 9) check1("seq_fault_c9", fetch_fault, 1'b1);
      tick();
    end
    check1("seq_drained", exp_q.size() == 0, 1'b1);

    // backpressure for 5 cycles after first valid
    redirect_to(32'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check1("bp_valid", out_valid, 1'b1);
      check32("bp_pc", out_pc, 32'h0);
      check32("bp_addr", imem_addr, 32'(4 * BUF_DEPTH));
      tick();
    end
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check1("bp_rel_valid", out_valid, 1'b1);
      check32("bp_rel_pc", out_pc, 32'(4 * k));
      tick();
    end
    drain_and_check(8);

    // redirect while 0x8 is in flight
    redirect_to(32'h0, 1'b1);
    tick();
    redirect_to(32'h10, 1'b1);
    drain_and_check(8);

    // misaligned redirect faults, legal redirect recovers
    redirect_to(32'h6, 1'b1);
    repeat (3) begin
      tick();
      check1("bad_valid", out_valid, 1'b0);
      check1("bad_fault", fetch_fault, 1'b1);
    end
    redirect_to(32'h4, 1'b1);
    drain_and_check(10);

    // redirect coincident with a pop at a full buffer
    redirect_to(32'h0, 1'b0);
    repeat (3) tick();
    check32("full_addr", imem_addr, 32'(4 * BUF_DEPTH));
    check1("full_valid", out_valid, 1'b1);
    redirect_to(32'h14, 1'b1);
    drain_and_check(8);

    // one-cycle reset mid-stream
    redirect_to(32'h0, 1'b1);
    repeat (2) tick();
    i_reset     = 1'b1;
    i_out_ready = 1'b0;
    tick();
    i_reset     = 1'b0;
    i_out_ready = 1'b1;
    check1("mrst_valid_c0", out_valid, 1'b0);
    check32("mrst_addr_c0", imem_addr, RESET_PC);
    check1("mrst_fault_c0", fetch_fault, 1'b0);
    check32("mrst_pc_c0", out_pc, 32'h0);
    tick();
    check1("mrst_valid_c1", out_valid, 1'b0);
    tick();
    check1("mrst_valid_c2", out_valid, 1'b1);
    check32("mrst_pc_c2", out_pc, RESET_PC);
    drain_and_check(10);

    // randomized ready and redirects
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        r = int'($urandom_range(0, 3));
        if (r != 0) t = 32'(4 * $urandom_range(0, MEM_WORDS - 1));
        else if ($urandom_range(0, 1) == 0)
          t = 32'(4 * $urandom_range(0, MEM_WORDS - 1) + $urandom_range(1, 3));
        else t = LIMIT + 32'(4 * $urandom_range(0, 100));
        redirect_to(t, 1'($urandom_range(0, 1)));
      end else begin
        i_out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    redirect_to(32'h0, 1'b1);
    drain_and_check(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
